pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL provide these ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- rs  in  5  ID-stage source register A
- rt  in  5  ID-stage source register B
- use_rs  in  1  ID instruction reads rs
- use_rt  in  1  ID instruction reads rt
- wreg  in  1  ID instruction writes the register file
- m2reg  in  1  ID instruction is a load
- wmem  in  1  ID instruction is a store
- rn  in  5  ID destination register (register-select mux output)
- dmem_ack  in  1  data memory completes the access this cycle
- wpcir  out  1  PC and IF/ID write enable; 0 holds both
- bubble  out  1  ID/EXE register captures zero controls (wreg/m2reg/wmem = 0)
- freeze  out  1  hold every pipeline register, ID/EXE included
- fwda  out  2  forward select for qa
- fwdb  out  2  forward select for qb
- stall_cnt  out  16  count of load-use stall cycles
- wait_cnt  out  16  count of memory-wait cycles

Function
REQ-002 The block SHALL keep shadow stage registers: E = {e_wreg, e_m2reg, e_wmem, e_rn}, then M = {m_wreg, m_m2reg, m_wmem, m_rn}.
REQ-003 When freeze=0, the block SHALL shift the shadow stages on each edge: M<=E, and E<=ID controls, or E<=zero controls when bubble=1.
REQ-004 When freeze=1, the block SHALL hold E and M unchanged.
REQ-005 The forward selects SHALL be combinational: 00 = register file, 01 = EXE ALU result, 10 = MEM ALU result, 11 = MEM load data.
REQ-006 Forwarding for an operand SHALL require a match on rs (fwda) or rt (fwdb), a nonzero register number, and the matching stage's wreg=1.
REQ-007 An EXE match SHALL take priority over a MEM match. On an EXE match with e_m2reg=0, the select SHALL be 01.
REQ-008 On a MEM-only match, the select SHALL be 11 if m_m2reg=1, else 10.
REQ-009 A load-use hazard SHALL be: e_wreg & e_m2reg & e_rn!=0 & ((use_rs & rs==e_rn) | (use_rt & rt==e_rn)).
REQ-010 On a load-use hazard with freeze=0, the block SHALL drive wpcir=0 and bubble=1 for exactly one cycle. The stall then self-clears because the load advances to M.
REQ-011 The memory-wait FSM SHALL have states IDLE and WAIT.
REQ-012 In IDLE, if M holds a memory op (m_m2reg|m_wmem) and dmem_ack=0, the FSM SHALL go to WAIT.
REQ-013 In WAIT, the FSM SHALL return to IDLE on dmem_ack=1.
REQ-014 freeze SHALL equal (m_m2reg|m_wmem) & ~dmem_ack, in either state. A zero-wait ack SHALL therefore never freeze.
REQ-015 freeze=1 SHALL force wpcir=0 and bubble=0. Freeze overrides the load-use stall, which is re-evaluated after the freeze releases.
REQ-016 stall_cnt SHALL increment on every cycle with bubble=1.
REQ-017 wait_cnt SHALL increment on every cycle with freeze=1.
REQ-018 Both counters SHALL be 16-bit and wrap from 0xFFFF to 0x0000.
REQ-019 Register 0 SHALL never cause forwarding or a stall.
REQ-020 A store's rn SHALL be ignored for hazards because its wreg is 0.

Reset
REQ-021 With rst=1 at an edge, the block SHALL clear E, M, stall_cnt and wait_cnt to 0 and set the FSM to IDLE.
REQ-022 Reset SHALL take priority over freeze and stall.
REQ-023 While rst=1, the outputs SHALL follow the cleared state: wpcir=1, bubble=0, freeze=0, fwda=fwdb=00.
REQ-024 Reset asserted in WAIT SHALL abandon the access with no residual freeze.

Structure
REQ-025 A shared package SHALL hold the fwd encodings (FWD_RF, FWD_EALU, FWD_MALU, FWD_MLD), the FSM state enum, and counter width 16.
REQ-026 One sub-module, fwd_sel, SHALL compute a single 2-bit select and be instantiated twice (rs, rt). All else SHALL stay flat.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- ADD r3 then ADD r4,r3,r3 -> fwda=fwdb=01; no stall.
- LW r5 then ADD r6,r5,r1 -> one cycle wpcir=0, bubble=1; next cycle fwda=11; stall_cnt=1.
- LW r5 with dmem_ack low 3 cycles -> freeze=1 for 3 cycles, FSM WAIT; release on ack; wait_cnt=3.
- Load-use coinciding with an older store's memory wait -> bubble=0 during freeze; a single bubble after release.
- Writes to r0 followed by reads of r0 -> fwd=00 and no stall; rst asserted mid-WAIT -> freeze=0 next cycle, counters 0.
- Preload stall_cnt to 0xFFFF via repeated stalls -> next stall wraps it to 0x0000.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, memory-wait FSM states, shadow stage record and widths.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // Operand source selects seen by the ID-stage operand muxes
  localparam logic [FWD_W-1:0] FWD_RF   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EALU = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MALU = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MLD  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mw_state_e;

  // Control bits of one in-flight instruction tracked by the shadow stages
  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic             wmem;
    logic [REG_W-1:0] rn;
  } stage_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forward select for one ID-stage source operand.
// Ports:
//   src             ID source register number
//   e_wreg/e_m2reg/e_rn  EXE shadow stage controls
//   m_wreg/m_m2reg/m_rn  MEM shadow stage controls
//   sel_c           combinational 2-bit operand source select
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [REG_W-1:0] e_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [REG_W-1:0] m_rn,
  output logic [FWD_W-1:0] sel_c
);

  logic src_nz;
  logic e_hit;
  logic m_hit;

  assign src_nz = (src != '0);
  assign e_hit  = src_nz & e_wreg & (src == e_rn);
  assign m_hit  = src_nz & m_wreg & (src == m_rn);

  // Youngest producer wins; a load still in EXE has no data yet and is
  // handled by the load-use stall, so it does not fall through to MEM.
  always_comb begin
    sel_c = FWD_RF;
    if (e_hit) begin
      if (!e_m2reg) sel_c = FWD_EALU;
    end else if (m_hit) begin
      sel_c = m_m2reg ? FWD_MLD : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks EXE/MEM shadow controls, selects
// operand forwarding, inserts load-use bubbles and freezes the pipe while
// data memory has not acknowledged an access.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rs, rt            ID source registers; use_rs/use_rt mark real reads
//   wreg/m2reg/wmem/rn  ID instruction controls and destination
//   dmem_ack          data memory completes the access this cycle
//   wpcir             PC / IF-ID write enable (0 holds)
//   bubble            ID/EXE captures zero controls
//   freeze            hold every pipeline register
//   fwda, fwdb        forward selects for qa / qb
//   stall_cnt, wait_cnt  wrapping event counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic        wreg,
  input  logic        m2reg,
  input  logic        wmem,
  input  logic [4:0]  rn,
  input  logic        dmem_ack,
  output logic        wpcir,
  output logic        bubble,
  output logic        freeze,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stall_cnt,
  output logic [15:0] wait_cnt
);

  stage_t    e_q;
  stage_t    m_q;
  stage_t    id_stage;
  mw_state_e state_q;
  mw_state_e state_d;

  logic             mem_op;
  logic             load_use;
  logic [FWD_W-1:0] fwda_c;
  logic [FWD_W-1:0] fwdb_c;

  assign id_stage = '{wreg: wreg, m2reg: m2reg, wmem: wmem, rn: rn};
  assign mem_op   = m_q.m2reg | m_q.wmem;

  // Outputs are masked by rst so they reflect the cleared state even
  // before the first reset edge has been seen.
  assign freeze = ~rst & mem_op & ~dmem_ack;

  assign load_use = ~rst & e_q.wreg & e_q.m2reg & (e_q.rn != '0) &
                    ((use_rs & (rs == e_q.rn)) | (use_rt & (rt == e_q.rn)));

  // Freeze overrides the stall; the hazard is re-evaluated once it lifts
  assign bubble = load_use & ~freeze;
  assign wpcir  = ~(load_use | freeze);

  fwd_sel u_fwd_a (
    .src     (rs),
    .e_wreg  (e_q.wreg),
    .e_m2reg (e_q.m2reg),
    .e_rn    (e_q.rn),
    .m_wreg  (m_q.wreg),
    .m_m2reg (m_q.m2reg),
    .m_rn    (m_q.rn),
    .sel_c   (fwda_c)
  );

  fwd_sel u_fwd_b (
    .src     (rt),
    .e_wreg  (e_q.wreg),
    .e_m2reg (e_q.m2reg),
    .e_rn    (e_q.rn),
    .m_wreg  (m_q.wreg),
    .m_m2reg (m_q.m2reg),
    .m_rn    (m_q.rn),
    .sel_c   (fwdb_c)
  );

  assign fwda = rst ? FWD_RF : fwda_c;
  assign fwdb = rst ? FWD_RF : fwdb_c;

  // Memory-wait FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op && !dmem_ack) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack)            state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Shadow stages, FSM state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      m_q       <= '0;
      state_q   <= ST_IDLE;
      stall_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      stall_cnt <= stall_cnt + CNT_W'(bubble);
      wait_cnt  <= wait_cnt + CNT_W'(freeze);
      if (!freeze) begin
        m_q <= e_q;
        e_q <= bubble ? stage_t'('0) : id_stage;
      end
    end
  end

endmodule
